// File: rtl/store_pkg.sv
// Shared definitions for the store path: size encodings and the queued entry layout.
package store_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WEN_W  = DATA_W / 8;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WEN_W-1:0]  wen;
  } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Lane alignment of store data/byte enables and misalignment detection.
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] data,
  output logic [WEN_W-1:0]  wen,
  output logic [DATA_W-1:0] wdata,
  output logic              ades
);

  // Shift data into its byte lanes; unused lanes keep the shifted data.
  always_comb begin
    wen   = '0;
    ades  = 1'b0;
    wdata = data << {offset, 3'b000};
    case (size)
      SZ_B: wen = 4'b0001 << offset;
      SZ_H: begin
        wen  = 4'b0011 << offset;
        ades = offset[0];
      end
      SZ_W: begin
        wen  = 4'b1111;
        ades = (offset != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_queue.sv
// Store FIFO between MEM stage and the data SRAM port, with load-hazard compare.
module store_queue
  import store_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 32'h1fff_ffff
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [1:0]                   st_size,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_data,
  output logic                         st_ades,
  output logic                         mem_req,
  output logic [WEN_W-1:0]             mem_wen,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_addr_ok,
  input  logic                         ld_valid,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hazard,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t             entries [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_W-1:0]   count_next;

  logic [WEN_W-1:0]   al_wen;
  logic [DATA_W-1:0]  al_wdata;
  logic               al_ades;
  logic               enq;
  logic               deq;
  logic [ADDR_W-1:0]  ld_phys;
  logic               ld_hit;
  entry_t             head;

  store_lane_align u_align (
    .size   (st_size),
    .offset (st_addr[1:0]),
    .data   (st_data),
    .wen    (al_wen),
    .wdata  (al_wdata),
    .ades   (al_ades)
  );

  assign st_ades  = st_valid & al_ades;
  assign st_ready = (count < CNT_W'(DEPTH));
  assign enq      = st_valid & st_ready & (st_size != SZ_NONE) & ~al_ades;
  assign mem_req  = ~empty;
  assign deq      = mem_req & mem_addr_ok;
  assign head     = entries[head_ptr];

  // Head entry presented to SRAM; zero when nothing is pending.
  always_comb begin
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!empty) begin
      mem_wen   = head.wen;
      mem_addr  = head.addr;
      mem_wdata = head.wdata;
    end
  end

  // Occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: ;
    endcase
  end

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      empty    <= 1'b1;
      valid    <= '0;
    end else begin
      count <= count_next;
      empty <= (count_next == '0);
      if (deq) begin
        head_ptr        <= head_ptr + PTR_W'(1);
        valid[head_ptr] <= 1'b0;
      end
      if (enq) begin
        tail_ptr        <= tail_ptr + PTR_W'(1);
        valid[tail_ptr] <= 1'b1;
      end
    end
  end

  // Entry payload storage; qualified by valid bits so no reset needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail_ptr] <= '{addr: st_addr & ADDR_MASK, wdata: al_wdata, wen: al_wen};
    end
  end

  assign ld_phys = ld_addr & ADDR_MASK;

  // Word-granular match of the load against every pending entry, head included.
  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[PTR_W'(i)] && (entries[PTR_W'(i)].addr[ADDR_W-1:2] == ld_phys[ADDR_W-1:2])) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_valid & ld_hit;

endmodule

// File: tb/tb_store_queue.sv
// Scoreboard bench for store_queue: predicted entries are queued on stimulus and
// popped when the DUT hands an entry to SRAM.
module tb_store_queue;
  import store_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ades;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int failures = 0;
  entry_t sb[$];

  store_queue #(.DEPTH(DEPTH), .ADDR_MASK(32'h1fff_ffff)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ades     (st_ades),
    .mem_req     (mem_req),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_hazard   (ld_hazard),
    .count       (count),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Independent model of the lane alignment.
  function automatic entry_t model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    entry_t e;
    e.addr  = a & 32'h1fff_ffff;
    e.wdata = d << (8 * a[1:0]);
    case (sz)
      2'b01:   e.wen = 4'b0001 << a[1:0];
      2'b10:   e.wen = 4'b0011 << a[1:0];
      default: e.wen = 4'b1111;
    endcase
    return e;
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b10 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
  endfunction

  // Drive a store for the coming edge and predict whether it is accepted.
  task automatic put_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    if (sz != 2'b00 && !misaligned(sz, a) && sb.size() < DEPTH) sb.push_back(model(sz, a, d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_idle();
    tick();
    st_valid = 1'b0;
  endtask

  // Scoreboard consumer: every SRAM handshake must match the oldest prediction.
  always @(negedge clk) begin
    if (!reset && mem_req && mem_addr_ok) begin
      if (sb.size() == 0) begin
        check("unexpected_drain", 32'(mem_req), 32'd0);
      end else begin
        entry_t e;
        e = sb.pop_front();
        check("drain_addr", mem_addr, e.addr);
        check("drain_wdata", mem_wdata, e.wdata);
        check("drain_wen", 32'(mem_wen), 32'(e.wen));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0;
    mem_addr_ok = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_st_ready", 32'(st_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Byte store at top lane, drained immediately.
    mem_addr_ok = 1'b1;
    put_store(2'b01, 32'h8000_0003, 32'h0000_00ab);
    #1 check("sb_ades", 32'(st_ades), 32'd0);
    tick_idle();
    check("sb_req", 32'(mem_req), 32'd1);
    check("sb_wen", 32'(mem_wen), 32'h8);
    check("sb_wdata", mem_wdata, 32'hab00_0000);
    check("sb_addr", mem_addr, 32'h0000_0003);
    tick();
    check("sb_empty_after", 32'(empty), 32'd1);

    // Misaligned and no-op stores leave the queue untouched.
    mem_addr_ok = 1'b0;
    put_store(2'b10, 32'h0000_0001, 32'h1234);
    #1 check("sh_mis_ades", 32'(st_ades), 32'd1);
    tick_idle();
    check("sh_mis_count", 32'(count), 32'd0);
    put_store(2'b11, 32'h0000_0002, 32'hdead_beef);
    #1 check("sw_mis_ades", 32'(st_ades), 32'd1);
    tick_idle();
    check("sw_mis_count", 32'(count), 32'd0);
    put_store(2'b00, 32'h0000_0000, 32'h5555_5555);
    #1 check("none_ades", 32'(st_ades), 32'd0);
    tick_idle();
    check("none_count", 32'(count), 32'd0);

    // Aligned halfword on upper half.
    put_store(2'b10, 32'h8000_0102, 32'h0000_1234);
    tick_idle();
    check("sh_wen", 32'(mem_wen), 32'hc);
    check("sh_wdata", mem_wdata, 32'h1234_0000);
    mem_addr_ok = 1'b1;
    tick();
    check("sh_empty", 32'(empty), 32'd1);
    mem_addr_ok = 1'b0;

    // Fill to DEPTH under back-pressure.
    for (int i = 0; i < 4; i++) begin
      put_store(2'b11, 32'h0000_0100 + 32'(i * 4), 32'h1111_0000 + 32'(i));
      tick();
    end
    st_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(st_ready), 32'd0);
    put_store(2'b11, 32'h0000_0200, 32'hbad0_bad0);
    tick_idle();
    check("full_held_count", 32'(count), 32'd4);

    // Enqueue attempt while full alongside a dequeue: only the dequeue happens.
    mem_addr_ok = 1'b1;
    put_store(2'b11, 32'h0000_0204, 32'hbad1_bad1);
    #1 check("full_deq_ready", 32'(st_ready), 32'd0);
    tick_idle();
    check("full_deq_count", 32'(count), 32'd3);
    for (int i = 2; i >= 0; i--) begin
      tick();
      check("drain_count", 32'(count), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous enqueue/dequeue at mid occupancy.
    mem_addr_ok = 1'b0;
    put_store(2'b01, 32'h0000_0300, 32'h11);
    tick();
    put_store(2'b01, 32'h0000_0301, 32'h22);
    tick();
    mem_addr_ok = 1'b1;
    put_store(2'b01, 32'h0000_0302, 32'h33);
    tick_idle();
    check("enq_deq_count", 32'(count), 32'd2);
    tick();
    tick();
    check("enq_deq_empty", 32'(empty), 32'd1);
    mem_addr_ok = 1'b0;

    // Load hazard compare.
    put_store(2'b11, 32'h0000_0010, 32'hcafe_f00d);
    tick_idle();
    ld_valid = 1'b1; ld_addr = 32'h8000_0012;
    #1 check("hz_match", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h0000_0014;
    #1 check("hz_other_word", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b0; ld_addr = 32'h0000_0010;
    #1 check("hz_no_load", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b1; ld_addr = 32'h0000_0020;
    put_store(2'b11, 32'h0000_0020, 32'h0bad_cafe);
    #1 check("hz_same_cycle", 32'(ld_hazard), 32'd0);
    tick_idle();
    check("hz_next_cycle", 32'(ld_hazard), 32'd1);
    mem_addr_ok = 1'b1;
    ld_addr = 32'h0000_0010;
    #1 check("hz_head_popping", 32'(ld_hazard), 32'd1);
    ld_valid = 1'b0;
    tick();
    tick();
    check("hz_drained", 32'(empty), 32'd1);
    mem_addr_ok = 1'b0;

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) begin
      put_store(2'b11, 32'h0000_0400 + 32'(i * 4), 32'h4444_0000 + 32'(i));
      tick();
    end
    st_valid = 1'b0;
    mem_addr_ok = 1'b1;
    tick();
    check("mid_drain_count", 32'(count), 32'd3);
    mem_addr_ok = 1'b0;
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_wen", 32'(mem_wen), 32'd0);
    tick();
    reset = 1'b0;
    put_store(2'b11, 32'h0000_0500, 32'h5050_5050);
    tick_idle();
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_req", 32'(mem_req), 32'd1);
    check("post_rst_addr", mem_addr, 32'h0000_0500);
    mem_addr_ok = 1'b1;
    begin
      int budget;
      budget = 0;
      while (!empty && budget < 10) begin
        tick();
        budget++;
      end
      check("final_empty", 32'(empty), 32'd1);
    end
    check("sb_leftover", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
